// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory pipeline stage: load/store codes,
// access FSM state encoding and exception-vector bit positions.
// No logic beyond a small decode helper.
package mem_stage_pkg;

    localparam logic [1:0] LDST_NONE = 2'b00;
    localparam logic [1:0] LDST_LD   = 2'b01;
    localparam logic [1:0] LDST_ST   = 2'b10;
    localparam logic [1:0] LDST_RSV  = 2'b11;   // reserved, treated as LDST_NONE

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam int EX_OVF    = 0;
    localparam int EX_BUSERR = 1;

    // Only real loads and stores touch memory; the reserved code does not.
    function automatic logic is_memop(input logic [1:0] code);
        return (code == LDST_LD) || (code == LDST_ST);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE -> ACCESS (request held) -> DONE.
// Latency: request rises the cycle after start; DONE follows the ack edge or timeout.
// Backpressure: holds DONE until the stage advances; request held until ack or timeout.
// Ports: clk/reset, advance (stage captures this edge), start (captured instr is a memop),
//        is_store, mem_ack in; mem_req, mem_we, done, timeout out.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic start,
    input  logic is_store,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic done,
    output logic timeout
);

    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic       timeout_q;

    // State, timeout counter and bus-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter measures cycles spent in the current ACCESS visit.
            if (state_q == ST_ACCESS && state_d == ST_ACCESS)
                cnt_q <= cnt_q + 8'd1;
            else
                cnt_q <= '0;
            // Flag is raised only when leaving ACCESS without an ack; an ack on
            // the expiry cycle still counts as success.
            if (state_q == ST_ACCESS && state_d == ST_DONE)
                timeout_q <= ~mem_ack;
            else if (state_d != ST_DONE)
                timeout_q <= 1'b0;
        end
    end

    // Next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ack || cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE:   if (advance) state_d = start ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs, all decoded from registers.
    always_comb begin
        mem_req = (state_q == ST_ACCESS);
        mem_we  = mem_req & is_store;
        done    = (state_q == ST_DONE);
        timeout = timeout_q;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the ALU result, performs load/store via req/ack, presents writeback.
// Latency: non-memop 1 cycle after capture; memop 1 cycle after the ack (or timeout) edge.
// Backpressure: stall_upstream holds the ALU stage while a captured memop has not reached DONE.
// Ports: ALU-stage inputs and sideband, mem_* request/ack bus, writeback outputs and forwarded fields.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_mem,
    input  logic              valid_input,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              OVF,
    input  logic [DATA_W-1:0] dataReg,
    input  logic [1:0]        ldSt_enable,
    input  logic [2:0]        destReg_addr,
    input  logic              we,
    input  logic [1:0]        bp_input,
    input  logic [2:0]        tail_rob_input,
    input  logic [15:0]       pc_input,
    input  logic [1:0]        ex_vector_input,
    input  logic              ticketWE_input,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_upstream,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        destReg_addr_output,
    output logic              we_output,
    output logic [1:0]        bp_output,
    output logic [2:0]        tail_rob_output,
    output logic [15:0]       pc_output,
    output logic [1:0]        ex_vector_output,
    output logic              ticketWE_output
);

    logic              valid_q, ovf_q, we_q, ticket_we_q;
    logic [DATA_W-1:0] alu_q, wdata_q, rdata_q;
    logic [1:0]        ldst_q, bp_q, ex_q;
    logic [2:0]        dest_q, tail_q;
    logic [15:0]       pc_q;

    logic capture, start, memop, is_store, is_load, done, timeout;

    assign capture  = enable_mem & ~stall_upstream;
    assign start    = capture & valid_input & is_memop(ldSt_enable);
    assign memop    = valid_q & is_memop(ldst_q);
    assign is_store = valid_q & (ldst_q == LDST_ST);
    assign is_load  = valid_q & (ldst_q == LDST_LD);

    // Input latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            ovf_q       <= 1'b0;
            wdata_q     <= '0;
            ldst_q      <= LDST_NONE;
            dest_q      <= '0;
            we_q        <= 1'b0;
            bp_q        <= '0;
            tail_q      <= '0;
            pc_q        <= '0;
            ex_q        <= '0;
            ticket_we_q <= 1'b0;
        end else if (capture) begin
            valid_q     <= valid_input;
            alu_q       <= alu_result;
            ovf_q       <= OVF;
            wdata_q     <= dataReg;
            ldst_q      <= ldSt_enable;
            dest_q      <= destReg_addr;
            we_q        <= we;
            bp_q        <= bp_input;
            tail_q      <= tail_rob_input;
            pc_q        <= pc_input;
            ex_q        <= ex_vector_input;
            ticket_we_q <= ticketWE_input;
        end
    end

    // Load data is taken only while a request is actually outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata_q <= '0;
        else if (mem_req && mem_ack && is_load)
            rdata_q <= mem_rdata;
    end

    mem_access_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .advance  (capture),
        .start    (start),
        .is_store (is_store),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .done     (done),
        .timeout  (timeout)
    );

    assign mem_addr       = alu_q;
    assign mem_wdata      = wdata_q;
    assign stall_upstream = memop & ~done;
    assign wb_valid       = valid_q & (~memop | done);

    // A timed-out load has no data; it falls back to the address like any non-load.
    assign wb_data   = (is_load && done && !timeout) ? rdata_q : alu_q;
    assign we_output = we_q & ~is_store & ~timeout;

    always_comb begin
        ex_vector_output            = ex_q;
        ex_vector_output[EX_OVF]    = ex_q[EX_OVF] | (ovf_q & ~memop);
        ex_vector_output[EX_BUSERR] = ex_q[EX_BUSERR] | timeout;
    end

    assign destReg_addr_output = dest_q;
    assign bp_output           = bp_q;
    assign tail_rob_output     = tail_q;
    assign pc_output           = pc_q;
    assign ticketWE_output     = ticket_we_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_mem, valid_input, OVF, we, ticketWE_input, mem_ack;
    logic [15:0] alu_result, dataReg, pc_input, mem_rdata;
    logic [1:0]  ldSt_enable, bp_input, ex_vector_input;
    logic [2:0]  destReg_addr, tail_rob_input;
    logic        mem_req, mem_we, stall_upstream, wb_valid, we_output, ticketWE_output;
    logic [15:0] mem_addr, mem_wdata, wb_data, pc_output;
    logic [2:0]  destReg_addr_output, tail_rob_output;
    logic [1:0]  bp_output, ex_vector_output;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .enable_mem(enable_mem), .valid_input(valid_input),
        .alu_result(alu_result), .OVF(OVF), .dataReg(dataReg), .ldSt_enable(ldSt_enable),
        .destReg_addr(destReg_addr), .we(we), .bp_input(bp_input),
        .tail_rob_input(tail_rob_input), .pc_input(pc_input),
        .ex_vector_input(ex_vector_input), .ticketWE_input(ticketWE_input),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_upstream(stall_upstream),
        .wb_valid(wb_valid), .wb_data(wb_data), .destReg_addr_output(destReg_addr_output),
        .we_output(we_output), .bp_output(bp_output), .tail_rob_output(tail_rob_output),
        .pc_output(pc_output), .ex_vector_output(ex_vector_output),
        .ticketWE_output(ticketWE_output)
    );

    typedef struct {
        logic        vld;
        logic [15:0] alu;
        logic        ovf;
        logic [15:0] dat;
        logic [1:0]  ldst;
        logic [2:0]  dest;
        logic        we;
        logic [1:0]  ex;
        logic [1:0]  bp;
        logic [2:0]  tail;
        logic [15:0] pc;
        logic        tw;
        // expected after one capture edge
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_we;
        logic [1:0]  e_ex;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        valid_input     = v.vld;
        alu_result      = v.alu;
        OVF             = v.ovf;
        dataReg         = v.dat;
        ldSt_enable     = v.ldst;
        destReg_addr    = v.dest;
        we              = v.we;
        ex_vector_input = v.ex;
        bp_input        = v.bp;
        tail_rob_input  = v.tail;
        pc_input        = v.pc;
        ticketWE_input  = v.tw;
    endtask

    function automatic vec_t mk(input logic [1:0] ldst, input logic [15:0] alu,
                                input logic [15:0] dat, input logic [2:0] dest);
        vec_t v;
        v = '{1'b1, alu, 1'b0, dat, ldst, dest, 1'b1, 2'b00, 2'b01, 3'd6, 16'h0200, 1'b0,
              1'b0, 16'h0, 1'b0, 2'b00};
        return v;
    endfunction

    // Runs an outstanding access; ack_at = 0 means never acknowledge.
    task automatic run_access(input string nm, input int ack_at, input logic [15:0] rd,
                              input logic [15:0] e_addr, input logic e_we,
                              input logic [15:0] e_wdata, output int reqs);
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            if (!mem_req) break;
            reqs++;
            chk({nm, " mem_addr"}, mem_addr, e_addr);
            chk({nm, " mem_we"}, mem_we, e_we);
            if (e_we) chk({nm, " mem_wdata"}, mem_wdata, e_wdata);
            chk({nm, " stall"}, stall_upstream, 1'b1);
            chk({nm, " wb_valid early"}, wb_valid, 1'b0);
            if (reqs == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        vec_t v;

        //          vld  alu       ovf  dat    ldst   dest we  ex     bp     tail  pc        tw    e_vld e_data   e_we e_ex
        vt[0] = '{1'b1, 16'h1234, 1'b0, 16'h0, 2'b00, 3'd5, 1'b1, 2'b00, 2'b10, 3'd3, 16'h0100, 1'b1, 1'b1, 16'h1234, 1'b1, 2'b00};
        vt[1] = '{1'b1, 16'h7FFF, 1'b1, 16'h0, 2'b00, 3'd2, 1'b1, 2'b00, 2'b01, 3'd1, 16'h0104, 1'b0, 1'b1, 16'h7FFF, 1'b1, 2'b01};
        vt[2] = '{1'b1, 16'h0055, 1'b0, 16'h0, 2'b11, 3'd4, 1'b1, 2'b00, 2'b11, 3'd7, 16'h0108, 1'b1, 1'b1, 16'h0055, 1'b1, 2'b00};
        vt[3] = '{1'b0, 16'h0BAD, 1'b0, 16'h0, 2'b01, 3'd1, 1'b1, 2'b00, 2'b00, 3'd2, 16'h010C, 1'b0, 1'b0, 16'h0BAD, 1'b1, 2'b00};
        vt[4] = '{1'b1, 16'h00F0, 1'b1, 16'h0, 2'b00, 3'd6, 1'b0, 2'b10, 2'b01, 3'd5, 16'h0110, 1'b0, 1'b1, 16'h00F0, 1'b0, 2'b11};

        reset = 1'b0; enable_mem = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
        v = '{default: '0};
        set_in(v);
        #12;
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset stall", stall_upstream, 1'b0);
        chk("reset wb_valid", wb_valid, 1'b0);
        chk("reset wb_data", wb_data, 16'h0);
        chk("reset we_output", we_output, 1'b0);
        chk("reset ex", ex_vector_output, 2'b00);
        chk("reset pc", pc_output, 16'h0);
        reset = 1'b1;
        tick();

        // Table: non-memory instructions, result one cycle after capture.
        for (int i = 0; i < 5; i++) begin
            set_in(vt[i]);
            tick();
            chk($sformatf("vec%0d wb_valid", i), wb_valid, vt[i].e_vld);
            chk($sformatf("vec%0d wb_data", i), wb_data, vt[i].e_data);
            chk($sformatf("vec%0d we_output", i), we_output, vt[i].e_we);
            chk($sformatf("vec%0d ex", i), ex_vector_output, vt[i].e_ex);
            chk($sformatf("vec%0d dest", i), destReg_addr_output, vt[i].dest);
            chk($sformatf("vec%0d bp", i), bp_output, vt[i].bp);
            chk($sformatf("vec%0d tail", i), tail_rob_output, vt[i].tail);
            chk($sformatf("vec%0d pc", i), pc_output, vt[i].pc);
            chk($sformatf("vec%0d ticketWE", i), ticketWE_output, vt[i].tw);
            chk($sformatf("vec%0d mem_req", i), mem_req, 1'b0);
            chk($sformatf("vec%0d stall", i), stall_upstream, 1'b0);
        end

        // Load, ack on the 3rd request cycle; a queued ADD must wait for DONE.
        set_in(mk(2'b01, 16'h0040, 16'h0, 3'd1));
        tick();
        set_in(mk(2'b00, 16'h0777, 16'h0, 3'd3));
        run_access("load", 3, 16'hBEEF, 16'h0040, 1'b0, 16'h0, reqs);
        chk("load req cycles", reqs, 3);
        chk("load wb_valid", wb_valid, 1'b1);
        chk("load wb_data", wb_data, 16'hBEEF);
        chk("load we_output", we_output, 1'b1);
        chk("load dest", destReg_addr_output, 3'd1);
        chk("load stall released", stall_upstream, 1'b0);
        tick();
        chk("next after load wb_data", wb_data, 16'h0777);
        chk("next after load dest", destReg_addr_output, 3'd3);
        chk("next after load wb_valid", wb_valid, 1'b1);

        // Store, ack in the first cycle, then hold with enable_mem low.
        set_in(mk(2'b10, 16'h0010, 16'h00AA, 3'd2));
        tick();
        enable_mem = 1'b0;
        run_access("store", 1, 16'h0, 16'h0010, 1'b1, 16'h00AA, reqs);
        chk("store req cycles", reqs, 1);
        chk("store wb_valid", wb_valid, 1'b1);
        chk("store we_output", we_output, 1'b0);
        chk("store wb_data", wb_data, 16'h0010);
        tick();
        chk("hold wb_valid", wb_valid, 1'b1);
        chk("hold mem_req", mem_req, 1'b0);
        chk("hold wb_data", wb_data, 16'h0010);
        enable_mem = 1'b1;

        // Load with no ack: bus error after exactly 4 request cycles.
        set_in(mk(2'b01, 16'h0020, 16'h0, 3'd4));
        tick();
        run_access("timeout", 0, 16'h0, 16'h0020, 1'b0, 16'h0, reqs);
        chk("timeout req cycles", reqs, 4);
        chk("timeout ex", ex_vector_output, 2'b10);
        chk("timeout we_output", we_output, 1'b0);
        chk("timeout stall", stall_upstream, 1'b0);
        chk("timeout wb_valid", wb_valid, 1'b1);

        // Ack on the expiry cycle counts as success.
        set_in(mk(2'b01, 16'h0030, 16'h0, 3'd5));
        tick();
        run_access("late ack", 4, 16'h1357, 16'h0030, 1'b0, 16'h0, reqs);
        chk("late ack req cycles", reqs, 4);
        chk("late ack ex", ex_vector_output, 2'b00);
        chk("late ack we_output", we_output, 1'b1);
        chk("late ack wb_data", wb_data, 16'h1357);

        // Reset during the 2nd request cycle.
        set_in(mk(2'b01, 16'h0050, 16'h0, 3'd6));
        tick();
        tick();
        chk("pre-reset mem_req", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid reset mem_req", mem_req, 1'b0);
        chk("mid reset stall", stall_upstream, 1'b0);
        chk("mid reset wb_valid", wb_valid, 1'b0);
        set_in(mk(2'b00, 16'h0999, 16'h0, 3'd7));
        #2;
        reset = 1'b1;
        tick();
        chk("post reset wb_valid", wb_valid, 1'b1);
        chk("post reset wb_data", wb_data, 16'h0999);
        chk("post reset mem_req", mem_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
